// File: rtl/axi4_pkg.sv
// Shared AXI4 field widths and encodings, plus the counter update-op type used by
// the outstanding-transaction limiter.
package axi4_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 512;
  localparam int STRB_W   = 64;
  localparam int ID_W     = 6;
  localparam int LEN_W    = 8;
  localparam int RESP_W   = 2;
  localparam int BURST_W  = 2;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;
  localparam int SIZE_W   = 3;

  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A same-cycle issue and completion cancel out, so only a lone event moves the count.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    cnt_op_e op;
    case ({inc, dec})
      2'b10:   op = CNT_INC;
      2'b01:   op = CNT_DEC;
      default: op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Saturating up/down count of in-flight transactions in one direction.
// Holds at MAX and at zero; underflow flags a completion that arrives with nothing in flight.
module outstanding_counter
  import axi4_pkg::*;
#(
  parameter  int MAX = 8,
  localparam int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  cnt_op_e       op_s;

  // Next-count selection with saturation at both ends.
  always_comb begin
    op_s        = cnt_op(inc, dec);
    count_nxt_s = count_r;
    case (op_s)
      CNT_INC: begin
        if (count_r != MAX_C) begin
          count_nxt_s = count_r + ONE_C;
        end else begin
          count_nxt_s = count_r;
        end
      end
      CNT_DEC: begin
        if (count_r != ZERO_C) begin
          count_nxt_s = count_r - ONE_C;
        end else begin
          count_nxt_s = count_r;
        end
      end
      CNT_HOLD: count_nxt_s = count_r;
      default:  count_nxt_s = count_r;
    endcase
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO_C;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign full      = (count_r == MAX_C);
  assign empty     = (count_r == ZERO_C);
  assign underflow = dec & ~inc & (count_r == ZERO_C);

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Caps in-flight AXI4 reads and writes ahead of axi_register_slice by gating AR/AW handshakes.
// W/R/B and all address payload fields pass straight through.
module axi_outstanding_limiter
  import axi4_pkg::*;
#(
  parameter  int MAX_READS  = 8,
  parameter  int MAX_WRITES = 8,
  localparam int CW_R       = $clog2(MAX_READS + 1),
  localparam int CW_W       = $clog2(MAX_WRITES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  // slave-side AR
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [BURST_W-1:0]  s_axi_arburst,
  input  logic [CACHE_W-1:0]  s_axi_arcache,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [LEN_W-1:0]    s_axi_arlen,
  input  logic                s_axi_arlock,
  input  logic [PROT_W-1:0]   s_axi_arprot,
  input  logic [QOS_W-1:0]    s_axi_arqos,
  input  logic [REGION_W-1:0] s_axi_arregion,
  input  logic [SIZE_W-1:0]   s_axi_arsize,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // slave-side AW
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [BURST_W-1:0]  s_axi_awburst,
  input  logic [CACHE_W-1:0]  s_axi_awcache,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [LEN_W-1:0]    s_axi_awlen,
  input  logic                s_axi_awlock,
  input  logic [PROT_W-1:0]   s_axi_awprot,
  input  logic [QOS_W-1:0]    s_axi_awqos,
  input  logic [REGION_W-1:0] s_axi_awregion,
  input  logic [SIZE_W-1:0]   s_axi_awsize,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // slave-side W
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [STRB_W-1:0]   s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // slave-side R
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [RESP_W-1:0]   s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // slave-side B
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [RESP_W-1:0]   s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // master-side AR
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [BURST_W-1:0]  m_axi_arburst,
  output logic [CACHE_W-1:0]  m_axi_arcache,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [LEN_W-1:0]    m_axi_arlen,
  output logic                m_axi_arlock,
  output logic [PROT_W-1:0]   m_axi_arprot,
  output logic [QOS_W-1:0]    m_axi_arqos,
  output logic [REGION_W-1:0] m_axi_arregion,
  output logic [SIZE_W-1:0]   m_axi_arsize,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // master-side AW
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [BURST_W-1:0]  m_axi_awburst,
  output logic [CACHE_W-1:0]  m_axi_awcache,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [LEN_W-1:0]    m_axi_awlen,
  output logic                m_axi_awlock,
  output logic [PROT_W-1:0]   m_axi_awprot,
  output logic [QOS_W-1:0]    m_axi_awqos,
  output logic [REGION_W-1:0] m_axi_awregion,
  output logic [SIZE_W-1:0]   m_axi_awsize,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // master-side W
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [STRB_W-1:0]   m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // master-side R
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [RESP_W-1:0]   m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // master-side B
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [RESP_W-1:0]   m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // control / status
  input  logic                quiesce,
  output logic                idle,
  output logic [CW_R-1:0]     rd_count,
  output logic [CW_W-1:0]     wr_count,
  output logic                error
);

  logic rd_blk_s, wr_blk_s;
  logic rd_inc_s, rd_dec_s, wr_inc_s, wr_dec_s;
  logic rd_full_s, rd_empty_s, rd_uf_s;
  logic wr_full_s, wr_empty_s, wr_uf_s;
  logic error_r;
  logic [CW_R-1:0] rd_count_s;
  logic [CW_W-1:0] wr_count_s;

  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arid     = s_axi_arid;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;
  assign m_axi_arsize   = s_axi_arsize;

  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awid     = s_axi_awid;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awregion = s_axi_awregion;
  assign m_axi_awsize   = s_axi_awsize;

  // W may run ahead of AW, so it is never gated.
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wvalid = s_axi_wvalid;
  assign s_axi_wready = m_axi_wready;

  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;

  // Gates use only registered fullness: a completion frees a slot one cycle later, never a bypass.
  assign rd_blk_s = reset | quiesce | rd_full_s;
  assign wr_blk_s = reset | quiesce | wr_full_s;

  assign m_axi_arvalid = s_axi_arvalid & ~rd_blk_s;
  assign s_axi_arready = m_axi_arready & ~rd_blk_s;
  assign m_axi_awvalid = s_axi_awvalid & ~wr_blk_s;
  assign s_axi_awready = m_axi_awready & ~wr_blk_s;

  assign rd_inc_s = m_axi_arvalid & m_axi_arready;
  assign rd_dec_s = s_axi_rvalid & s_axi_rready & s_axi_rlast;
  assign wr_inc_s = m_axi_awvalid & m_axi_awready;
  assign wr_dec_s = s_axi_bvalid & s_axi_bready;

  outstanding_counter #(.MAX(MAX_READS)) u_rd_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (rd_inc_s),
    .dec       (rd_dec_s),
    .count     (rd_count_s),
    .full      (rd_full_s),
    .empty     (rd_empty_s),
    .underflow (rd_uf_s)
  );

  outstanding_counter #(.MAX(MAX_WRITES)) u_wr_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc       (wr_inc_s),
    .dec       (wr_dec_s),
    .count     (wr_count_s),
    .full      (wr_full_s),
    .empty     (wr_empty_s),
    .underflow (wr_uf_s)
  );

  // Sticky error: stale or spurious completions seen with nothing in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else if (rd_uf_s | wr_uf_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign rd_count = rd_count_s;
  assign wr_count = wr_count_s;
  assign idle     = rd_empty_s & wr_empty_s;
  assign error    = error_r;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed scoreboard bench: dut_a (2 reads / 4 writes) covers gating and counting,
// dut_b (8 / 8) covers reset from a deeper read count. Both share the same stimulus.
module tb_axi_outstanding_limiter;
  import axi4_pkg::*;

  logic clk = 1'b0;
  logic reset, quiesce;

  logic [63:0] s_axi_araddr, s_axi_awaddr;
  logic [1:0]  s_axi_arburst, s_axi_awburst;
  logic [3:0]  s_axi_arcache, s_axi_awcache, s_axi_arqos, s_axi_awqos, s_axi_arregion, s_axi_awregion;
  logic [5:0]  s_axi_arid, s_axi_awid, m_axi_rid, m_axi_bid;
  logic [7:0]  s_axi_arlen, s_axi_awlen;
  logic        s_axi_arlock, s_axi_awlock, s_axi_arvalid, s_axi_awvalid, m_axi_arready, m_axi_awready;
  logic [2:0]  s_axi_arprot, s_axi_awprot, s_axi_arsize, s_axi_awsize;
  logic [511:0] s_axi_wdata, m_axi_rdata;
  logic [63:0] s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_rlast, m_axi_rvalid, s_axi_rready, m_axi_bvalid, s_axi_bready;

  // dut_a outputs
  logic [63:0] a_araddr, a_awaddr;
  logic [1:0]  a_arburst, a_awburst, a_rresp, a_bresp;
  logic [3:0]  a_arcache, a_awcache, a_arqos, a_awqos, a_arregion, a_awregion;
  logic [5:0]  a_arid, a_awid, a_rid, a_bid;
  logic [7:0]  a_arlen, a_awlen;
  logic [2:0]  a_arprot, a_awprot, a_arsize, a_awsize;
  logic        a_arlock, a_awlock, a_arvalid, a_arready, a_awvalid, a_awready;
  logic [511:0] a_wdata, a_rdata;
  logic [63:0] a_wstrb;
  logic        a_wlast, a_wvalid, a_wready, a_rlast, a_rvalid, a_rready, a_bvalid, a_bready;
  logic        a_idle, a_error;
  logic [1:0]  a_rd_count;
  logic [2:0]  a_wr_count;

  // dut_b outputs
  logic [63:0] b_araddr, b_awaddr;
  logic [1:0]  b_arburst, b_awburst, b_rresp, b_bresp;
  logic [3:0]  b_arcache, b_awcache, b_arqos, b_awqos, b_arregion, b_awregion;
  logic [5:0]  b_arid, b_awid, b_rid, b_bid;
  logic [7:0]  b_arlen, b_awlen;
  logic [2:0]  b_arprot, b_awprot, b_arsize, b_awsize;
  logic        b_arlock, b_awlock, b_arvalid, b_arready, b_awvalid, b_awready;
  logic [511:0] b_wdata, b_rdata;
  logic [63:0] b_wstrb;
  logic        b_wlast, b_wvalid, b_wready, b_rlast, b_rvalid, b_rready, b_bvalid, b_bready;
  logic        b_idle, b_error;
  logic [3:0]  b_rd_count, b_wr_count;

  axi_outstanding_limiter #(.MAX_READS(2), .MAX_WRITES(4)) dut_a (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache), .s_axi_arid(s_axi_arid),
    .s_axi_arlen(s_axi_arlen), .s_axi_arlock(s_axi_arlock), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(a_arready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache), .s_axi_awid(s_axi_awid),
    .s_axi_awlen(s_axi_awlen), .s_axi_awlock(s_axi_awlock), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(a_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(a_wready),
    .s_axi_rdata(a_rdata), .s_axi_rid(a_rid), .s_axi_rresp(a_rresp), .s_axi_rlast(a_rlast), .s_axi_rvalid(a_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bid(a_bid), .s_axi_bresp(a_bresp), .s_axi_bvalid(a_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_araddr(a_araddr), .m_axi_arburst(a_arburst), .m_axi_arcache(a_arcache), .m_axi_arid(a_arid),
    .m_axi_arlen(a_arlen), .m_axi_arlock(a_arlock), .m_axi_arprot(a_arprot), .m_axi_arqos(a_arqos),
    .m_axi_arregion(a_arregion), .m_axi_arsize(a_arsize), .m_axi_arvalid(a_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(a_awaddr), .m_axi_awburst(a_awburst), .m_axi_awcache(a_awcache), .m_axi_awid(a_awid),
    .m_axi_awlen(a_awlen), .m_axi_awlock(a_awlock), .m_axi_awprot(a_awprot), .m_axi_awqos(a_awqos),
    .m_axi_awregion(a_awregion), .m_axi_awsize(a_awsize), .m_axi_awvalid(a_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_wlast(a_wlast), .m_axi_wvalid(a_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(a_rready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(a_bready),
    .quiesce(quiesce), .idle(a_idle), .rd_count(a_rd_count), .wr_count(a_wr_count), .error(a_error)
  );

  axi_outstanding_limiter #(.MAX_READS(8), .MAX_WRITES(8)) dut_b (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache), .s_axi_arid(s_axi_arid),
    .s_axi_arlen(s_axi_arlen), .s_axi_arlock(s_axi_arlock), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(b_arready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache), .s_axi_awid(s_axi_awid),
    .s_axi_awlen(s_axi_awlen), .s_axi_awlock(s_axi_awlock), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awregion(s_axi_awregion), .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(b_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(b_wready),
    .s_axi_rdata(b_rdata), .s_axi_rid(b_rid), .s_axi_rresp(b_rresp), .s_axi_rlast(b_rlast), .s_axi_rvalid(b_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_bid(b_bid), .s_axi_bresp(b_bresp), .s_axi_bvalid(b_bvalid), .s_axi_bready(s_axi_bready),
    .m_axi_araddr(b_araddr), .m_axi_arburst(b_arburst), .m_axi_arcache(b_arcache), .m_axi_arid(b_arid),
    .m_axi_arlen(b_arlen), .m_axi_arlock(b_arlock), .m_axi_arprot(b_arprot), .m_axi_arqos(b_arqos),
    .m_axi_arregion(b_arregion), .m_axi_arsize(b_arsize), .m_axi_arvalid(b_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_awaddr(b_awaddr), .m_axi_awburst(b_awburst), .m_axi_awcache(b_awcache), .m_axi_awid(b_awid),
    .m_axi_awlen(b_awlen), .m_axi_awlock(b_awlock), .m_axi_awprot(b_awprot), .m_axi_awqos(b_awqos),
    .m_axi_awregion(b_awregion), .m_axi_awsize(b_awsize), .m_axi_awvalid(b_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wlast(b_wlast), .m_axi_wvalid(b_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(b_rready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(b_bready),
    .quiesce(quiesce), .idle(b_idle), .rd_count(b_rd_count), .wr_count(b_wr_count), .error(b_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0]  ar_q[$];
  logic [63:0]  aw_q[$];
  logic [511:0] w_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar(input logic [63:0] addr);
    s_axi_araddr  = addr;
    s_axi_arid    = addr[11:6];
    s_axi_arvalid = 1'b1;
    ar_q.push_back(addr);
  endtask

  task automatic drive_aw(input logic [63:0] addr);
    s_axi_awaddr  = addr;
    s_axi_awid    = addr[11:6];
    s_axi_awvalid = 1'b1;
    aw_q.push_back(addr);
  endtask

  task automatic expect_ar_accept(input string tag);
    chk({tag, "_hs"}, {a_arvalid, a_arready}, 2'b11);
    if (ar_q.size() == 0) begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=queued", tag);
    end else begin
      chk({tag, "_addr"}, a_araddr, ar_q.pop_front());
    end
  endtask

  task automatic expect_aw_accept(input string tag);
    chk({tag, "_hs"}, {a_awvalid, a_awready}, 2'b11);
    if (aw_q.size() == 0) begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=queued", tag);
    end else begin
      chk({tag, "_addr"}, a_awaddr, aw_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; quiesce = 1'b0;
    s_axi_araddr = 64'd0; s_axi_arburst = BURST_INCR; s_axi_arcache = 4'h3; s_axi_arid = 6'd0;
    s_axi_arlen = 8'd3; s_axi_arlock = 1'b0; s_axi_arprot = 3'd0; s_axi_arqos = 4'd0;
    s_axi_arregion = 4'd0; s_axi_arsize = 3'd6; s_axi_arvalid = 1'b0; m_axi_arready = 1'b0;
    s_axi_awaddr = 64'd0; s_axi_awburst = BURST_INCR; s_axi_awcache = 4'h3; s_axi_awid = 6'd0;
    s_axi_awlen = 8'd0; s_axi_awlock = 1'b0; s_axi_awprot = 3'd0; s_axi_awqos = 4'd0;
    s_axi_awregion = 4'd0; s_axi_awsize = 3'd6; s_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
    s_axi_wdata = 512'd0; s_axi_wstrb = {64{1'b1}}; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b0; m_axi_wready = 1'b0;
    m_axi_rdata = 512'd0; m_axi_rid = 6'd0; m_axi_rresp = RESP_OKAY; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    s_axi_rready = 1'b0; m_axi_bid = 6'd0; m_axi_bresp = RESP_OKAY; m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
    tick(); tick();

    // address gates shut and R passes while reset is held
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b1; s_axi_awvalid = 1'b1; m_axi_awready = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rdata = {8{64'hDEAD_BEEF_0000_0001}}; s_axi_rready = 1'b1;
    #1;
    chk("rst_m_arvalid", a_arvalid, 1'b0);
    chk("rst_s_arready", a_arready, 1'b0);
    chk("rst_m_awvalid", a_awvalid, 1'b0);
    chk("rst_r_pass", a_rvalid, 1'b1);
    chk("rst_rdata", a_rdata, {8{64'hDEAD_BEEF_0000_0001}});
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; m_axi_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_rd_count", a_rd_count, 2'd0);
    chk("rst_wr_count", a_wr_count, 3'd0);
    chk("rst_idle", a_idle, 1'b1);
    chk("rst_error", a_error, 1'b0);

    // three back-to-back ARs against a cap of two
    drive_ar(64'h1000); #1; expect_ar_accept("t1_ar0");
    tick(); drive_ar(64'h1040); #1; expect_ar_accept("t1_ar1");
    chk("t1_cnt1", a_rd_count, 2'd1);
    tick(); drive_ar(64'h1080); #1;
    chk("t1_hold_ready", a_arready, 1'b0);
    chk("t1_hold_valid", a_arvalid, 1'b0);
    chk("t1_cnt2", a_rd_count, 2'd2);
    tick();
    chk("t1_still_held", a_arready, 1'b0);

    // rlast in the same cycle as the waiting AR: no bypass
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = {16{32'hA5A5_0002}}; #1;
    chk("t2_blocked", a_arready, 1'b0);
    chk("t2_rlast_pass", a_rlast, 1'b1);
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; #1;
    chk("t2_cnt_drop", a_rd_count, 2'd1);
    expect_ar_accept("t2_ar2");
    tick();
    s_axi_arvalid = 1'b0;
    chk("t2_cnt_full", a_rd_count, 2'd2);

    // four-beat burst, rlast only on the final beat
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = 1'b1; m_axi_rlast = (i == 3); m_axi_rdata = {16{32'(i)}};
      tick();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      chk($sformatf("t4_beat%0d", i), a_rd_count, (i == 3) ? 2'd1 : 2'd2);
    end

    // writes: fill to 3, then simultaneous AW and B
    for (int i = 0; i < 3; i++) begin
      drive_aw(64'h2000 + 64'(i * 64)); #1;
      expect_aw_accept($sformatf("t3_aw%0d", i));
      tick();
    end
    chk("t3_cnt3", a_wr_count, 3'd3);
    drive_aw(64'h2100); m_axi_bvalid = 1'b1; s_axi_bready = 1'b1; #1;
    expect_aw_accept("t3_aw_b");
    chk("t3_b_pass", a_bvalid, 1'b1);
    tick();
    s_axi_awvalid = 1'b0;
    chk("t3_cnt_same", a_wr_count, 3'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_drain%0d", i), a_wr_count, 3'(2 - i));
    end
    chk("t3_no_err_yet", a_error, 1'b0);
    tick();
    m_axi_bvalid = 1'b0;
    chk("t3_uf_cnt", a_wr_count, 3'd0);
    chk("t3_uf_err", a_error, 1'b1);
    tick();
    chk("t3_err_sticky", a_error, 1'b1);
    drive_aw(64'h3000); #1; expect_aw_accept("t3_aw_last");
    tick();
    s_axi_awvalid = 1'b0;
    chk("t3_wr1", a_wr_count, 3'd1);

    // quiesce with one read and one write in flight; W still flows
    quiesce = 1'b1;
    s_axi_araddr = 64'h4000; s_axi_arvalid = 1'b1; s_axi_awaddr = 64'h5000; s_axi_awvalid = 1'b1;
    s_axi_wdata = {8{64'h0123_4567_89AB_CDEF}}; w_q.push_back({8{64'h0123_4567_89AB_CDEF}});
    s_axi_wvalid = 1'b1; m_axi_wready = 1'b1; #1;
    chk("t5_arvalid", a_arvalid, 1'b0);
    chk("t5_arready", a_arready, 1'b0);
    chk("t5_awvalid", a_awvalid, 1'b0);
    chk("t5_awready", a_awready, 1'b0);
    chk("t5_w_hs", {a_wvalid, a_wready}, 2'b11);
    chk("t5_wdata", a_wdata, w_q.pop_front());
    chk("t5_busy", a_idle, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("t5_rd0", a_rd_count, 2'd0);
    chk("t5_not_idle", a_idle, 1'b0);
    m_axi_bvalid = 1'b1;
    tick();
    m_axi_bvalid = 1'b0;
    chk("t5_wr0", a_wr_count, 3'd0);
    chk("t5_idle", a_idle, 1'b1);
    tick();
    chk("t5_still_gated", {a_arready, a_awready}, 2'b00);
    quiesce = 1'b0; s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;

    // reset with five reads outstanding on the deeper instance
    reset = 1'b1; tick(); reset = 1'b0;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    s_axi_arvalid = 1'b0;
    chk("t6_b_cnt5", b_rd_count, 4'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_b_cnt0", b_rd_count, 4'd0);
    chk("t6_b_idle", b_idle, 1'b1);
    chk("t6_b_err0", b_error, 1'b0);
    chk("t6_a_err0", a_error, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("t6_stale_err", b_error, 1'b1);
    chk("t6_stale_cnt", b_rd_count, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
